// File: rtl/zipomem.sv
// Single-port 64-bit memory responder for the zipocpu memory port.
// Zero-fills the whole array after every reset, then serves one read or write per cycle.
module zipomem #(
  parameter logic [63:0] BASE_ADDR  = 64'h0,
  parameter int          DEPTH_LOG2 = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rw,
  input  logic [63:0] addr,
  input  logic [63:0] write,
  output logic [63:0] read,
  output logic        busy,
  output logic        err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] LAST_WORD = '1;
  // Range end kept in 65 bits so a window ending at 2^64 does not wrap to zero.
  localparam logic [64:0] LIMIT = {1'b0, BASE_ADDR} + (65'd1 << (DEPTH_LOG2 + 3));

  typedef enum logic {
    S_INIT,
    S_RUN
  } state_t;

  state_t                  state;
  logic [DEPTH_LOG2-1:0]   fill_cnt;
  logic [63:0]             mem [DEPTH];

  logic                    hit;
  logic [63:0]             offset;
  logic [DEPTH_LOG2-1:0]   idx;
  logic                    unused_offset_bits;

  logic                    mem_we;
  logic [DEPTH_LOG2-1:0]   mem_idx;
  logic [63:0]             mem_wdata;

  // offset is only meaningful on a hit; on a miss idx is never used to touch the array.
  assign hit    = ({1'b0, addr} >= {1'b0, BASE_ADDR}) && ({1'b0, addr} < LIMIT);
  assign offset = addr - BASE_ADDR;
  assign idx    = offset[DEPTH_LOG2+2:3];
  assign unused_offset_bits = ^{offset[63:DEPTH_LOG2+3], offset[2:0]};

  // Single array write port shared between the zero-fill and RUN-state writes.
  always_comb begin
    mem_we    = 1'b0;
    mem_idx   = idx;
    mem_wdata = write;
    if (state == S_INIT) begin
      mem_we    = 1'b1;
      mem_idx   = fill_cnt;
      mem_wdata = '0;
    end else if (hit && rw) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && mem_we) begin
      mem[mem_idx] <= mem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_INIT;
      fill_cnt <= '0;
      read     <= '0;
      busy     <= 1'b1;
      err      <= 1'b0;
    end else begin
      case (state)
        S_INIT: begin
          fill_cnt <= fill_cnt + 1'b1;
          if (fill_cnt == LAST_WORD) begin
            state <= S_RUN;
            busy  <= 1'b0;
          end
        end
        S_RUN: begin
          if (hit) begin
            // Write-first: a write returns its own data on the same cycle.
            if (rw) begin
              read <= write;
            end else begin
              read <= mem[idx];
            end
          end else begin
            read <= '0;
            err  <= 1'b1;
          end
        end
        default: state <= S_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_zipomem.sv
// Bench for zipomem: directed scenarios plus random traffic, checked by a queued
// scoreboard against a word-array reference model.
module tb_zipomem;

  localparam logic [63:0] BASE   = 64'h0;
  localparam logic [63:0] BASE_B = 64'h1000;
  localparam int          WORDS  = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rw = 1'b0;
  logic [63:0] addr = '0;
  logic [63:0] write = '0;
  logic [63:0] read;
  logic        busy;
  logic        err;

  logic        rw_b = 1'b0;
  logic [63:0] addr_b = BASE_B;
  logic [63:0] write_b = '0;
  logic [63:0] read_b;
  logic        busy_b;
  logic        err_b;

  int n_tests = 0;
  int n_fail  = 0;

  logic        req_active = 1'b0;
  logic [63:0] exp_q[$];
  logic        exp_err_q[$];
  logic [63:0] mem_model [WORDS];
  logic        err_model = 1'b0;

  zipomem #(.BASE_ADDR(BASE), .DEPTH_LOG2(4)) dut (
    .clk(clk), .rst_n(rst_n), .rw(rw), .addr(addr), .write(write),
    .read(read), .busy(busy), .err(err)
  );

  zipomem #(.BASE_ADDR(BASE_B), .DEPTH_LOG2(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .rw(rw_b), .addr(addr_b), .write(write_b),
    .read(read_b), .busy(busy_b), .err(err_b)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: flat array of words plus a sticky error bit.
  task automatic req(input logic w, input logic [63:0] a, input logic [63:0] d);
    logic [64:0] lim;
    logic        h;
    int          i;
    logic [63:0] e;
    @(negedge clk);
    rw = w; addr = a; write = d; req_active = 1'b1;
    lim = {1'b0, BASE} + 65'd8 * WORDS;
    h = ({1'b0, a} >= {1'b0, BASE}) && ({1'b0, a} < lim);
    if (h) begin
      i = int'((a - BASE) / 8);
      if (w) begin
        mem_model[i] = d;
        e = d;
      end else begin
        e = mem_model[i];
      end
    end else begin
      e = '0;
      err_model = 1'b1;
    end
    exp_q.push_back(e);
    exp_err_q.push_back(err_model);
  endtask

  task automatic idle();
    @(negedge clk);
    req_active = 1'b0;
    rw = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 10) begin
      @(posedge clk);
      k++;
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d responses outstanding, required 0", exp_q.size());
      exp_q.delete();
      exp_err_q.delete();
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst_n = 1'b0;
    req_active = 1'b0;
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      #1;
      check("reset_read", read, 64'h0);
      check("reset_busy", {63'h0, busy}, 64'h1);
      check("reset_err", {63'h0, err}, 64'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < WORDS; i++) mem_model[i] = '0;
    err_model = 1'b0;
  endtask

  // Counts edges until busy drops; optionally issues writes that must be ignored.
  task automatic wait_fill(input int expected, input logic junk);
    int cnt;
    if (junk) begin
      rw = 1'b1; addr = 64'h0; write = 64'hFFFF;
    end
    cnt = 0;
    while (cnt < 100) begin
      @(posedge clk);
      #1;
      cnt++;
      if (!busy) break;
      check("init_read", read, 64'h0);
      check("init_err", {63'h0, err}, 64'h0);
    end
    check("fill_cycles", 64'(cnt), 64'(expected));
    check("fill_busy_b", {63'h0, busy_b}, 64'h0);
    rw = 1'b0;
  endtask

  // Monitor: every edge that sampled a request must produce the queued response.
  initial begin
    logic        active;
    logic [63:0] e;
    logic        ee;
    forever begin
      @(posedge clk);
      active = req_active;
      #1;
      if (active) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL monitor: response with empty expected queue, read %h", read);
        end else begin
          e  = exp_q.pop_front();
          ee = exp_err_q.pop_front();
          check("read", read, e);
          check("err", {63'h0, err}, {63'h0, ee});
        end
      end
    end
  end

  initial begin
    logic [63:0] a;
    // 1: reset and fill
    do_reset(3);
    wait_fill(16, 1'b0);
    for (int i = 0; i < WORDS; i++) req(1'b0, 64'(i * 8), '0);
    idle(); drain();

    // 2: write then read, sub-word address aliasing
    req(1'b1, 64'h10, 64'hDEADBEEF_CAFEF00D);
    req(1'b0, 64'h14, '0);
    req(1'b0, 64'h18, '0);
    idle(); drain();

    // 3: back-to-back streaming
    for (int i = 0; i < WORDS; i++) req(1'b1, 64'(i * 8), 64'(i) * 64'h0101);
    for (int i = 0; i < WORDS; i++) req(1'b0, 64'(i * 8), '0);
    idle(); drain();

    // random in-range traffic, writes and reads interleaved
    for (int n = 0; n < 150; n++) begin
      a = 64'($urandom_range(0, 8 * WORDS - 1));
      req(1'($urandom_range(0, 1)), a, {$urandom, $urandom});
    end
    idle(); drain();

    // 4: out-of-range accesses
    req(1'b0, 64'h80, '0);
    req(1'b0, 64'h0, '0);
    req(1'b1, 64'h88, 64'h1234_5678_9ABC_DEF0);
    for (int i = 0; i < WORDS; i++) req(1'b0, 64'(i * 8), '0);
    idle(); drain();

    @(negedge clk);
    rw_b = 1'b0; addr_b = 64'h1008;
    @(posedge clk); #1;
    check("b_hit_read", read_b, 64'h0);
    check("b_hit_err", {63'h0, err_b}, 64'h0);
    @(negedge clk);
    addr_b = 64'hFF8;
    @(posedge clk); #1;
    check("b_miss_read", read_b, 64'h0);
    check("b_miss_err", {63'h0, err_b}, 64'h1);
    @(negedge clk);
    addr_b = BASE_B;
    @(posedge clk); #1;
    check("b_err_sticky", {63'h0, err_b}, 64'h1);

    // 5: reset in RUN, then again at fill count 7
    for (int i = 0; i < WORDS; i++) req(1'b1, 64'(i * 8), 64'hA5A5_0000_0000_0000 | 64'(i + 1));
    idle(); drain();
    do_reset(1);
    repeat (7) @(posedge clk);
    do_reset(1);
    wait_fill(16, 1'b0);
    check("err_cleared", {63'h0, err}, 64'h0);
    for (int i = 0; i < WORDS; i++) req(1'b0, 64'(i * 8), '0);
    idle(); drain();

    // 6: requests during INIT are ignored
    do_reset(1);
    wait_fill(16, 1'b1);
    req(1'b0, 64'h0, '0);
    idle(); drain();

    // random traffic including misses
    for (int n = 0; n < 150; n++) begin
      a = 64'($urandom_range(0, 8 * WORDS + 31));
      req(1'($urandom_range(0, 1)), a, {$urandom, $urandom});
    end
    idle(); drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
